// File: rtl/bram_arb_pkg.sv
// Shared types for the two-port BRAM arbiter: FSM states and grant encoding.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module bram_arb_rr
  import bram_arb_pkg::*;
(
  input  logic   if_valid,
  input  logic   d_valid,
  input  grant_t last_gnt,
  output logic   grant_any,
  output grant_t winner
);

  always_comb begin
    grant_any = if_valid | d_valid;
    if (if_valid && d_valid) begin
      winner = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
    end else if (d_valid) begin
      winner = GNT_D;
    end else begin
      winner = GNT_IF;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port, 1-cycle-latency BRAM between instruction fetch (read-only) and
// load/store (read/write). Writes finish in the grant cycle; reads go issue -> capture -> hold.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  input  logic                  i_if_req_valid,
  output logic                  o_if_req_ready,
  output logic [DATA_WIDTH-1:0] o_if_data,
  output logic                  o_if_rsp_valid,
  input  logic                  i_if_rsp_ready,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  input  logic                  i_d_we,
  input  logic                  i_d_req_valid,
  output logic                  o_d_req_ready,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic                  o_d_rsp_valid,
  input  logic                  i_d_rsp_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_write,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  arb_state_t            state_q, state_d;
  grant_t                last_gnt_q, winner_q, winner;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] if_data_q, d_data_q;
  logic                  if_rsp_valid_q, d_rsp_valid_q;
  logic                  wr_grant, rd_grant, rsp_done;

  bram_arb_rr u_rr (
    .if_valid  (i_if_req_valid),
    .d_valid   (i_d_req_valid),
    .last_gnt  (last_gnt_q),
    .grant_any (grant_any),
    .winner    (winner)
  );

  always_comb begin
    state_d        = state_q;
    o_if_req_ready = 1'b0;
    o_d_req_ready  = 1'b0;
    o_mem_addr     = addr_q;
    o_mem_wdata    = i_d_wdata;
    wr_grant       = 1'b0;
    rd_grant       = 1'b0;
    rsp_done       = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        o_mem_addr = (winner == GNT_D) ? i_d_addr : i_if_addr;
        // Readies and write enable are gated by reset so nothing is accepted while held.
        if (grant_any && i_rst_n) begin
          o_if_req_ready = (winner == GNT_IF);
          o_d_req_ready  = (winner == GNT_D);
          wr_grant       = (winner == GNT_D) && i_d_we;
          rd_grant       = !wr_grant;
          if (rd_grant) state_d = ARB_RD;
        end
      end
      ARB_RD: state_d = ARB_RSP;
      ARB_RSP: begin
        rsp_done = (winner_q == GNT_IF) ? i_if_rsp_ready : i_d_rsp_ready;
        if (rsp_done) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign o_mem_write = wr_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ARB_IDLE;
      last_gnt_q     <= GNT_D;
      winner_q       <= GNT_D;
      addr_q         <= '0;
      if_data_q      <= '0;
      d_data_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && grant_any) last_gnt_q <= winner;
      if (rd_grant) begin
        addr_q   <= o_mem_addr;
        winner_q <= winner;
      end
      if (state_q == ARB_RD) begin
        if (winner_q == GNT_IF) begin
          if_data_q      <= i_mem_rdata;
          if_rsp_valid_q <= 1'b1;
        end else begin
          d_data_q      <= i_mem_rdata;
          d_rsp_valid_q <= 1'b1;
        end
      end
      if (rsp_done) begin
        if_rsp_valid_q <= 1'b0;
        d_rsp_valid_q  <= 1'b0;
      end
    end
  end

  assign o_if_data      = if_data_q;
  assign o_if_rsp_valid = if_rsp_valid_q;
  assign o_d_rdata      = d_data_q;
  assign o_d_rsp_valid  = d_rsp_valid_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: grant vector table, response scoreboard, corner sequences.
module tb_bram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_if_addr, i_d_addr, o_mem_addr;
  logic        i_if_req_valid, o_if_req_ready, o_if_rsp_valid, i_if_rsp_ready;
  logic        i_d_we, i_d_req_valid, o_d_req_ready, o_d_rsp_valid, i_d_rsp_ready;
  logic [31:0] o_if_data, i_d_wdata, o_d_rdata, o_mem_wdata, i_mem_rdata;
  logic        o_mem_write;

  bram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_if_addr      (i_if_addr),
    .i_if_req_valid (i_if_req_valid),
    .o_if_req_ready (o_if_req_ready),
    .o_if_data      (o_if_data),
    .o_if_rsp_valid (o_if_rsp_valid),
    .i_if_rsp_ready (i_if_rsp_ready),
    .i_d_addr       (i_d_addr),
    .i_d_wdata      (i_d_wdata),
    .i_d_we         (i_d_we),
    .i_d_req_valid  (i_d_req_valid),
    .o_d_req_ready  (o_d_req_ready),
    .o_d_rdata      (o_d_rdata),
    .o_d_rsp_valid  (o_d_rsp_valid),
    .i_d_rsp_ready  (i_d_rsp_ready),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_write    (o_mem_write),
    .i_mem_rdata    (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] init_word(input int a);
    logic [7:0] b;
    b = a[7:0];
    return (a == 5) ? 32'hfff00693 : {8'hc3, b, ~b, 8'h5a};
  endfunction

  // Read-first BRAM model, loaded on the first edge (reset holds writes off then).
  logic [31:0] bram [256];
  bit          bram_loaded = 1'b0;
  always @(posedge i_clk) begin
    if (!bram_loaded) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
      bram_loaded <= 1'b1;
    end else begin
      i_mem_rdata <= bram[o_mem_addr];
      if (o_mem_write) bram[o_mem_addr] <= o_mem_wdata;
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        if_v;
    logic        d_v;
    logic        d_we;
    logic [7:0]  if_a;
    logic [7:0]  d_a;
    logic [31:0] wd;
    int          gnt;  // 0 none, 1 fetch, 2 data
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] hold_if, hold_d;
  bit          rsp_active;
  int          cyc, errors, checks;
  vec_t        vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic next();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  // Per-cycle scoreboard, called at the negedge of every cycle.
  task automatic monitor();
    logic        port;
    logic [31:0] data;
    logic        hs;
    if (!i_rst_n) begin
      exp_q.delete();
      rsp_active = 1'b0;
      hold_if = '0;
      hold_d = '0;
      return;
    end
    chk("single_grant", {31'd0, o_if_req_ready & o_d_req_ready}, 32'd0);
    chk("write_only_on_d_write", {31'd0, o_mem_write},
        {31'd0, i_d_req_valid & o_d_req_ready & i_d_we});
    if (i_d_req_valid && o_d_req_ready && i_d_we) begin
      chk("write_addr", {24'd0, o_mem_addr}, {24'd0, i_d_addr});
      chk("write_data", o_mem_wdata, i_d_wdata);
      ref_mem[i_d_addr] = i_d_wdata;
    end else if (i_d_req_valid && o_d_req_ready) begin
      exp_q.push_back('{port: 1'b1, data: ref_mem[i_d_addr], due: cyc + 2});
    end
    if (i_if_req_valid && o_if_req_ready)
      exp_q.push_back('{port: 1'b0, data: ref_mem[i_if_addr], due: cyc + 2});

    chk("rsp_one_port", {31'd0, o_if_rsp_valid & o_d_rsp_valid}, 32'd0);
    if (!o_if_rsp_valid) chk("if_data_held", o_if_data, hold_if);
    if (!o_d_rsp_valid) chk("d_rdata_held", o_d_rdata, hold_d);
    if (o_if_rsp_valid || o_d_rsp_valid) begin
      port = o_d_rsp_valid;
      data = port ? o_d_rdata : o_if_data;
      hs   = port ? i_d_rsp_ready : i_if_rsp_ready;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {31'd0, port}, 32'hffffffff);
      end else begin
        chk("rsp_port", {31'd0, port}, {31'd0, exp_q[0].port});
        chk("rsp_data", data, exp_q[0].data);
        if (!rsp_active) chk("rsp_latency", cyc, exp_q[0].due);
        rsp_active = 1'b1;
        if (hs) begin
          if (port) hold_d = data;
          else hold_if = data;
          void'(exp_q.pop_front());
          rsp_active = 1'b0;
        end
      end
    end else if (rsp_active) begin
      chk("rsp_dropped", 32'd0, 32'd1);
      rsp_active = 1'b0;
    end
  endtask

  task automatic sample();
    @(negedge i_clk);
    monitor();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && (exp_q.size() != 0); i++) begin
      next();
      sample();
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; errors = 0; checks = 0;
    rsp_active = 1'b0; hold_if = '0; hold_d = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    //             if_v  d_v   d_we  if_a   d_a    wd            gnt
    vt[0] = '{1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 32'h0,        1};
    vt[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h40, 32'h11223344, 2};
    vt[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 32'h0,        2};
    vt[3] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h40, 32'h0,        1};
    vt[4] = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h41, 32'hcafe0041, 2};
    vt[5] = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h41, 32'h0,        0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h41, 32'h0,        1};
    vt[7] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h41, 32'h0,        2};

    // Reset holds readies and write enable low even with requests present.
    i_rst_n = 1'b0;
    i_if_addr = 8'h05; i_if_req_valid = 1'b1; i_if_rsp_ready = 1'b1;
    i_d_addr = 8'h40; i_d_wdata = 32'h0; i_d_we = 1'b1; i_d_req_valid = 1'b1;
    i_d_rsp_ready = 1'b1;
    next(); next(); sample();
    chk("rst_if_ready", {31'd0, o_if_req_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, o_d_req_ready}, 32'd0);
    chk("rst_mem_write", {31'd0, o_mem_write}, 32'd0);
    chk("rst_if_rsp_valid", {31'd0, o_if_rsp_valid}, 32'd0);
    chk("rst_d_rsp_valid", {31'd0, o_d_rsp_valid}, 32'd0);
    chk("rst_if_data", o_if_data, 32'd0);
    chk("rst_d_rdata", o_d_rdata, 32'd0);
    next();
    i_rst_n = 1'b1; i_if_req_valid = 1'b0; i_d_req_valid = 1'b0; i_d_we = 1'b0;
    sample();

    // Grant table from reset (last grant = data).
    for (int i = 0; i < 8; i++) begin
      next();
      i_if_req_valid = vt[i].if_v; i_d_req_valid = vt[i].d_v; i_d_we = vt[i].d_we;
      i_if_addr = vt[i].if_a; i_d_addr = vt[i].d_a; i_d_wdata = vt[i].wd;
      sample();
      chk($sformatf("vec%0d_if_ready", i), {31'd0, o_if_req_ready}, {31'd0, vt[i].gnt == 1});
      chk($sformatf("vec%0d_d_ready", i), {31'd0, o_d_req_ready}, {31'd0, vt[i].gnt == 2});
      chk($sformatf("vec%0d_mem_write", i), {31'd0, o_mem_write},
          {31'd0, (vt[i].gnt == 2) && vt[i].d_we});
      if (vt[i].gnt != 0)
        chk($sformatf("vec%0d_mem_addr", i), {24'd0, o_mem_addr},
            {24'd0, (vt[i].gnt == 2) ? vt[i].d_a : vt[i].if_a});
      next();
      i_if_req_valid = 1'b0; i_d_req_valid = 1'b0; i_d_we = 1'b0;
      sample();
      wait_idle();
    end

    // Fetch response held 4 cycles while data waits; data granted right after handshake.
    next();
    i_if_req_valid = 1'b1; i_if_addr = 8'h05; i_if_rsp_ready = 1'b0;
    i_d_req_valid = 1'b1; i_d_addr = 8'h41; i_d_we = 1'b0;
    sample();
    chk("hold_if_granted", {31'd0, o_if_req_ready}, 32'd1);
    chk("hold_d_blocked0", {31'd0, o_d_req_ready}, 32'd0);
    next();
    i_if_req_valid = 1'b0;
    sample();
    chk("hold_d_blocked_rd", {31'd0, o_d_req_ready}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      next(); sample();
      chk($sformatf("hold_d_blocked%0d", k), {31'd0, o_d_req_ready}, 32'd0);
      chk($sformatf("hold_if_valid%0d", k), {31'd0, o_if_rsp_valid}, 32'd1);
    end
    next();
    i_if_rsp_ready = 1'b1;
    sample();
    chk("hold_d_blocked_hs", {31'd0, o_d_req_ready}, 32'd0);
    next(); sample();
    chk("hold_d_granted", {31'd0, o_d_req_ready}, 32'd1);
    next();
    i_d_req_valid = 1'b0;
    sample();
    wait_idle();

    // Both ports requesting reads continuously: IF, D, IF, D.
    next();
    i_if_req_valid = 1'b1; i_if_addr = 8'h10;
    i_d_req_valid = 1'b1; i_d_addr = 8'h40; i_d_we = 1'b0;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      sample();
      while (!(o_if_req_ready || o_d_req_ready) && n < 10) begin
        next(); sample(); n++;
      end
      chk($sformatf("alt%0d_granted", g), {31'd0, o_if_req_ready | o_d_req_ready}, 32'd1);
      chk($sformatf("alt%0d_if", g), {31'd0, o_if_req_ready}, {31'd0, (g % 2) == 0});
      next();
    end
    i_if_req_valid = 1'b0; i_d_req_valid = 1'b0;
    sample();
    wait_idle();

    // Reset while a fetch response is being held drops it at once.
    next();
    i_if_req_valid = 1'b1; i_if_addr = 8'h10; i_if_rsp_ready = 1'b0;
    sample();
    chk("rstrsp_granted", {31'd0, o_if_req_ready}, 32'd1);
    next();
    i_if_req_valid = 1'b0;
    sample();
    next(); sample();
    chk("rstrsp_valid_before", {31'd0, o_if_rsp_valid}, 32'd1);
    next();
    #2 i_rst_n = 1'b0;
    #1;
    chk("rstrsp_valid_drop", {31'd0, o_if_rsp_valid}, 32'd0);
    chk("rstrsp_data_clear", o_if_data, 32'd0);
    sample();
    next();
    i_rst_n = 1'b1; i_if_rsp_ready = 1'b1;
    sample();
    for (int k = 0; k < 4; k++) begin
      next(); sample();
    end

    // Reset during the capture cycle: no response afterwards, next tie goes to fetch.
    next();
    i_if_req_valid = 1'b1; i_if_addr = 8'h05;
    sample();
    chk("rstrd_granted", {31'd0, o_if_req_ready}, 32'd1);
    next();
    i_if_req_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rstrd_if_valid", {31'd0, o_if_rsp_valid}, 32'd0);
    sample();
    next(); sample();
    next();
    i_rst_n = 1'b1;
    sample();
    for (int k = 0; k < 4; k++) begin
      next(); sample();
      chk($sformatf("rstrd_no_rsp%0d", k), {31'd0, o_if_rsp_valid}, 32'd0);
    end
    next();
    i_if_req_valid = 1'b1; i_if_addr = 8'h10;
    i_d_req_valid = 1'b1; i_d_addr = 8'h41; i_d_we = 1'b0;
    sample();
    chk("rstrd_tie_if", {31'd0, o_if_req_ready}, 32'd1);
    chk("rstrd_tie_d", {31'd0, o_d_req_ready}, 32'd0);
    next();
    i_if_req_valid = 1'b0; i_d_req_valid = 1'b0;
    sample();
    wait_idle();

    // Fetch was last granted: a contending store to 0xff wins, then fetch reads it back.
    next();
    i_if_req_valid = 1'b1; i_if_addr = 8'hff;
    i_d_req_valid = 1'b1; i_d_addr = 8'hff; i_d_we = 1'b1; i_d_wdata = 32'hdeadbeef;
    sample();
    chk("wr_d_ready", {31'd0, o_d_req_ready}, 32'd1);
    chk("wr_if_ready", {31'd0, o_if_req_ready}, 32'd0);
    chk("wr_mem_write", {31'd0, o_mem_write}, 32'd1);
    chk("wr_mem_addr", {24'd0, o_mem_addr}, 32'h000000ff);
    chk("wr_mem_wdata", o_mem_wdata, 32'hdeadbeef);
    next();
    i_d_req_valid = 1'b0; i_d_we = 1'b0;
    sample();
    chk("wr_then_if_ready", {31'd0, o_if_req_ready}, 32'd1);
    chk("wr_then_no_write", {31'd0, o_mem_write}, 32'd0);
    next();
    i_if_req_valid = 1'b0;
    sample();
    wait_idle();
    chk("readback_ff", hold_if, 32'hdeadbeef);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
Two-requester arbiter that shares one single-port, 1-cycle-latency BRAM between the instruction-fetch port (read-only) and the load/store data port (read/write). It sits between the core's fetch/LSU units and the raw BRAM, replacing the ready/valid BRAM wrapper. It sequences each read through issue, capture and response-hold phases, and applies round-robin grant on contention.

Parameters:
DATA_WIDTH, 32, word width of BRAM and both ports
ADDR_WIDTH, 8, BRAM word-address width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_if_addr  in  ADDR_WIDTH  fetch word address
i_if_req_valid  in  1  fetch request valid
o_if_req_ready  out  1  fetch request accepted this cycle
o_if_data  out  DATA_WIDTH  fetch read data
o_if_rsp_valid  out  1  fetch response valid
i_if_rsp_ready  in  1  fetch consumer ready
i_d_addr  in  ADDR_WIDTH  data word address
i_d_wdata  in  DATA_WIDTH  store data
i_d_we  in  1  1 = write, 0 = read
i_d_req_valid  in  1  data request valid
o_d_req_ready  out  1  data request accepted this cycle
o_d_rdata  out  DATA_WIDTH  load data
o_d_rsp_valid  out  1  load response valid
i_d_rsp_ready  in  1  load consumer ready
o_mem_addr  out  ADDR_WIDTH  BRAM address
o_mem_wdata  out  DATA_WIDTH  BRAM write data
o_mem_write  out  1  BRAM write enable
i_mem_rdata  in  DATA_WIDTH  BRAM read data, valid 1 cycle after address

Behaviour:
- Reset: i_rst_n low asynchronously forces state=ARB_IDLE, last_gnt=GNT_D, rsp data regs=0, both rsp_valid=0. While i_rst_n is low, both req_ready=0 and o_mem_write=0 (gated combinationally).
- FSM states: ARB_IDLE, ARB_RD, ARB_RSP.
- ARB_IDLE grant:
  - only one req_valid: that port wins.
  - both valid: port != last_gnt wins (round-robin). First tie after reset goes to fetch.
- ARB_IDLE outputs (combinational): winner's req_ready=1, loser's req_ready=0; o_mem_addr=winner addr; o_mem_wdata=i_d_wdata; o_mem_write=(winner==GNT_D && i_d_we). last_gnt<=winner on any grant.
- Write (data winner, i_d_we=1): completes in the grant cycle, no response, state stays ARB_IDLE. Back-to-back writes at 1/cycle when uncontended.
- Read grant: latch addr and winner; go to ARB_RD.
- ARB_RD: o_mem_addr=latched addr, o_mem_write=0, req_readys=0. Capture i_mem_rdata into the winner's rsp data reg and set its rsp_valid; go to ARB_RSP.
- ARB_RSP:
  - rsp_valid held, data stable, until the matching rsp_ready.
  - On handshake: rsp_valid<=0, go to ARB_IDLE.
  - No new grant while in ARB_RSP.
- Read latency: accept at cycle T, rsp_valid at T+2. Minimum read period 3 cycles.
- Non-winning port's rsp_valid stays 0. o_if_data/o_d_rdata hold their last value outside a response.
- BRAM is read-first: a read of an address written in an earlier cycle returns new data. Fetch and store are never both issued in one cycle.
- Request inputs are sampled only in the grant cycle; they may change freely in other states.
- i_rst_n low mid-read (ARB_RD/ARB_RSP) drops the pending response with no completion.
- Addresses wrap naturally at ADDR_WIDTH bits; no range checks.

Decomposition:
- Package bram_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_RD, ARB_RSP}
  - typedef enum logic grant_t {GNT_IF=0, GNT_D=1}
- Sub-module bram_arb_rr: 2-way round-robin pick, combinational.
  - inputs: two valids, last_gnt
  - outputs: grant_any, winner

Test Plan:
- Reset, mem[5]=32'hfff00693; fetch addr 5 valid, rsp_ready=1 -> req_ready at T, o_if_rsp_valid=1 with 32'hfff00693 at T+2, idle at T+3.
- Data write addr 8'h40 data 32'h11223344, then data read addr 8'h40 -> o_mem_write pulses 1 cycle; o_d_rdata=32'h11223344, o_d_rsp_valid at read-accept+2.
- Both ports valid continuously, reads, rsp_ready=1 -> grants alternate IF, D, IF, D; first grant IF; each rsp on correct port only.
- Fetch read with i_if_rsp_ready=0 for 4 cycles, data req pending -> o_if_rsp_valid and data held stable; o_d_req_ready=0 throughout; data granted the cycle after the rsp handshake.
- Assert i_rst_n=0 asynchronously in ARB_RD -> o_if_rsp_valid=0 immediately, no response after release; first tie after release goes to fetch.
- Data write 32'hdeadbeef to addr 8'hff while fetch valid (fetch last granted) -> data wins; o_mem_addr=8'hff, o_mem_write=1; fetch granted next cycle.
